// File: rtl/seq_div_32by16_if.sv
// Handshake bundle for the sequential 2N/N restoring divider.
// The master modport belongs to the producer/consumer side and the slave
// modport belongs to the divider itself.
interface seq_div_32by16_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, err
    );
endinterface

// File: rtl/seq_div_32by16.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per clock. Divide-by-zero and quotient overflow are caught
// at acceptance time and reported with err, an all-ones quotient and a zero
// remainder.
module seq_div_32by16 #(
    parameter int N = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_div_32by16_if.slave   bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [N-1:0]  rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  divisor_q;
    logic          err_q;
    logic [CW-1:0] count_q;

    logic          accept;
    logic          div_error;
    logic          last_step;
    logic [N:0]    trial;
    logic          borrow;

    assign accept    = bus.in_valid && (state == IDLE);

    // A quotient fits in N bits only when the upper half of the dividend is
    // strictly smaller than the divisor; this also covers divisor == 0.
    assign div_error = (bus.divisor == '0) || (bus.dividend[2*N-1:N] >= bus.divisor);

    assign last_step = (count_q == CW'(N - 1));

    // The shifted partial remainder is always below 2*divisor, so the top
    // bit of the (N+1)-bit difference is exactly the borrow out.
    assign trial  = {rem_q, quo_q[N-1]} - {1'b0, divisor_q};
    assign borrow = trial[N];

    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
    assign bus.err       = err_q;

    // State register; asynchronous reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, N shift/subtract steps, wait for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = div_error ? DONE : DIV;
                end
            end
            DIV: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so no input reaches them combinationally.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load operands on acceptance, then one restoring step per DIV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        divisor_q <= bus.divisor;
                        count_q   <= '0;
                        if (div_error) begin
                            err_q <= 1'b1;
                            quo_q <= '1;
                            rem_q <= '0;
                        end else begin
                            err_q <= 1'b0;
                            rem_q <= bus.dividend[2*N-1:N];
                            quo_q <= bus.dividend[N-1:0];
                        end
                    end
                end
                DIV: begin
                    count_q <= count_q + CW'(1);
                    if (!borrow) begin
                        rem_q <= trial[N-1:0];
                        quo_q <= {quo_q[N-2:0], 1'b1};
                    end else begin
                        rem_q <= {rem_q[N-2:0], quo_q[N-1]};
                        quo_q <= {quo_q[N-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
